// File: rtl/bfly_stage_ctrl.sv
// Sequencer for one radix-2 single-delay-feedback FFT stage. The first half of each
// frame is buffered. Second-half samples are paired with it for the external butterfly.
// The stage then emits the sums, followed by the buffered differences.
module bfly_stage_ctrl #(
  parameter int WIDTH    = 12,
  parameter int NUM_PAIR = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_re,
  input  logic [WIDTH-1:0]            in_im,
  output logic                        bf_valid,
  output logic [WIDTH-1:0]            bf_a_re,
  output logic [WIDTH-1:0]            bf_a_im,
  output logic [WIDTH-1:0]            bf_b_re,
  output logic [WIDTH-1:0]            bf_b_im,
  input  logic [WIDTH:0]              bf_sum_re,
  input  logic [WIDTH:0]              bf_sum_im,
  input  logic [WIDTH:0]              bf_diff_re,
  input  logic [WIDTH:0]              bf_diff_im,
  output logic                        out_valid,
  output logic [WIDTH:0]              out_re,
  output logic [WIDTH:0]              out_im,
  output logic                        out_is_diff,
  output logic [$clog2(NUM_PAIR)-1:0] out_idx,
  output logic                        frame_done
);

  localparam int KW = $clog2(NUM_PAIR);
  localparam int BW = 2 * (WIDTH + 1);

  typedef enum logic [1:0] {S_FILL, S_PAIR, S_FLUSH, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [KW-1:0]   r_k;
  logic            r_flush_cnt;
  logic [BW-1:0]   r_buf [NUM_PAIR];
  logic [BW-1:0]   w_rd;
  logic            w_hs;
  logic            w_k_last;
  logic            w_issue;

  logic            r_bf_valid;
  logic [WIDTH-1:0] r_bf_a_re, r_bf_a_im, r_bf_b_re, r_bf_b_im;
  logic [KW-1:0]   r_bf_idx;
  logic            r_res_pend;
  logic [KW-1:0]   r_res_idx;

  logic            r_out_valid;
  logic [WIDTH:0]  r_out_re, r_out_im;
  logic            r_out_is_diff;
  logic [KW-1:0]   r_out_idx;
  logic            r_frame_done;

  assign w_hs     = in_valid && in_ready;
  assign w_k_last = (r_k == KW'(NUM_PAIR - 1));
  assign w_issue  = (r_state == S_PAIR) && w_hs && !clr;
  assign w_rd     = r_buf[r_k];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_FILL;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = S_FILL;
    end else begin
      case (r_state)
        S_FILL:  if (w_hs && w_k_last) w_state_next = S_PAIR;
        S_PAIR:  if (w_hs && w_k_last) w_state_next = S_FLUSH;
        S_FLUSH: if (r_flush_cnt)      w_state_next = S_DRAIN;
        S_DRAIN: if (w_k_last)         w_state_next = S_FILL;
        default:                       w_state_next = S_FILL;
      endcase
    end
  end

  always_comb begin
    in_ready = (r_state == S_FILL) || (r_state == S_PAIR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_k         <= '0;
      r_flush_cnt <= 1'b0;
    end else if (clr) begin
      r_k         <= '0;
      r_flush_cnt <= 1'b0;
    end else begin
      case (r_state)
        S_FILL, S_PAIR: if (w_hs) r_k <= w_k_last ? '0 : r_k + KW'(1);
        S_FLUSH:        r_flush_cnt <= ~r_flush_cnt;
        S_DRAIN:        r_k <= w_k_last ? '0 : r_k + KW'(1);
        default:        r_k <= '0;
      endcase
    end
  end

  // r_res_pend marks the cycle in which the butterfly's results for r_res_idx are present.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bf_valid <= 1'b0;
      r_bf_a_re  <= '0;
      r_bf_a_im  <= '0;
      r_bf_b_re  <= '0;
      r_bf_b_im  <= '0;
      r_bf_idx   <= '0;
      r_res_pend <= 1'b0;
      r_res_idx  <= '0;
    end else begin
      r_bf_valid <= w_issue;
      r_res_pend <= r_bf_valid && !clr;
      r_res_idx  <= r_bf_idx;
      if (w_issue) begin
        r_bf_a_re <= w_rd[WIDTH+1 +: WIDTH];
        r_bf_a_im <= w_rd[0 +: WIDTH];
        r_bf_b_re <= in_re;
        r_bf_b_im <= in_im;
        r_bf_idx  <= r_k;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid   <= 1'b0;
      r_out_re      <= '0;
      r_out_im      <= '0;
      r_out_is_diff <= 1'b0;
      r_out_idx     <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (!clr) begin
        if (r_res_pend) begin
          r_out_valid   <= 1'b1;
          r_out_re      <= bf_sum_re;
          r_out_im      <= bf_sum_im;
          r_out_is_diff <= 1'b0;
          r_out_idx     <= r_res_idx;
        end else if (r_state == S_DRAIN) begin
          r_out_valid   <= 1'b1;
          r_out_re      <= w_rd[BW-1:WIDTH+1];
          r_out_im      <= w_rd[WIDTH:0];
          r_out_is_diff <= 1'b1;
          r_out_idx     <= r_k;
          r_frame_done  <= w_k_last;
        end
      end
    end
  end

  // Diff write-back lands two cycles after issue, so buf[k] still holds the first-half sample when read.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (r_res_pend)
        r_buf[r_res_idx] <= {bf_diff_re, bf_diff_im};
      else if (r_state == S_FILL && w_hs)
        r_buf[r_k] <= {in_re[WIDTH-1], in_re, in_im[WIDTH-1], in_im};
    end
  end

  assign bf_valid    = r_bf_valid;
  assign bf_a_re     = r_bf_a_re;
  assign bf_a_im     = r_bf_a_im;
  assign bf_b_re     = r_bf_b_re;
  assign bf_b_im     = r_bf_b_im;
  assign out_valid   = r_out_valid;
  assign out_re      = r_out_re;
  assign out_im      = r_out_im;
  assign out_is_diff = r_out_is_diff;
  assign out_idx     = r_out_idx;
  assign frame_done  = r_frame_done;

endmodule

// File: doc/bfly_stage_ctrl.md
# bfly_stage_ctrl

Sequencer for one radix-2 single-delay-feedback FFT stage built around the external butterfly datapath. It accepts a stream of `2*NUM_PAIR` complex samples per frame. The first half goes into a delay buffer. Each second-half sample is paired with buffer entry `k` and issued to the butterfly. The block then streams out the sums followed by the buffered differences, each tagged with its twiddle index for the downstream twiddle multiplier.

## Interface
Parameters:
- `WIDTH`, 12, input sample width per component (signed)
- `NUM_PAIR`, 16, pairs per frame (frame length `2*NUM_PAIR`). Legal values: power of two, ≥2.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge
- `rstn`  in  1  reset; one clock, asynchronous, active-low
- `clr`  in  1  synchronous abort: discard the partial frame and return to FILL
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  input accept; `in_ready = (state==FILL || state==PAIR)`
- `in_re`, `in_im`  in  WIDTH each  signed input sample
- `bf_valid`  out  1  butterfly operand valid (registered)
- `bf_a_re`, `bf_a_im`  out  WIDTH each  first-half operand (buffered sample), registered
- `bf_b_re`, `bf_b_im`  out  WIDTH each  second-half operand (current input), registered
- `bf_sum_re`, `bf_sum_im`  in  WIDTH+1 each  butterfly a+b; valid exactly 1 cycle after `bf_valid`
- `bf_diff_re`, `bf_diff_im`  in  WIDTH+1 each  butterfly a−b; same timing as the sum
- `out_valid`  out  1  output sample valid. There is no backpressure.
- `out_re`, `out_im`  out  WIDTH+1 each  output sample
- `out_is_diff`  out  1  0 = sum half, 1 = difference half
- `out_idx`  out  $clog2(NUM_PAIR)  pair index k (twiddle index for diff outputs)
- `frame_done`  out  1  one-cycle pulse coincident with the last diff output

## Operation
- Storage: buffer array of `NUM_PAIR` × 2×(WIDTH+1). Pair counter `k` is $clog2(NUM_PAIR) bits wide.
- States: FILL, PAIR, FLUSH, DRAIN. The reset state is FILL with `k=0`.
- FILL
  - On each handshake (`in_valid && in_ready`), write the sign-extended input to `buf[k]` and increment `k`.
  - At `k==NUM_PAIR-1` with a handshake: go to PAIR and set `k=0`.
  - Cycles without a handshake hold state.
- PAIR
  - On a handshake, register `bf_a = buf[k][WIDTH-1:0]`, `bf_b = in`, `bf_valid=1` for the next cycle, and increment `k`.
  - Results arrive 1 cycle after `bf_valid`:
    - sum → output register (`out_is_diff=0`, `out_idx=k`);
    - diff → written to `buf[k]` in that same cycle.
  - At the last handshake (`k==NUM_PAIR-1`): go to FLUSH and set `k=0`.
  - `buf[k]` still holds the input sample at issue time, because the diff write happens 2 cycles later.
- FLUSH
  - Fixed 2 cycles, with `in_ready=0`.
  - Guarantees the last diff write lands before DRAIN reads it. This is required for `NUM_PAIR=2`.
- DRAIN
  - `NUM_PAIR` consecutive cycles, with `in_ready=0`.
  - Each cycle reads `buf[k]` into the output register (`out_is_diff=1`, `out_idx=k`) and increments `k`.
  - After reading `k==NUM_PAIR-1`: go to FILL and set `k=0`.
- Arithmetic: the controller does no arithmetic and no saturation. Butterfly results are passed through at full WIDTH+1.
- `clr`
  - Takes priority over all transitions.
  - Next state is FILL with `k=0`.
  - Pending `bf_valid`, `out_valid` and `frame_done` are forced to 0 next cycle.
  - Results that return after `clr` are ignored (a tracking pipeline bit is also cleared).
  - Buffer contents are don't-care.

## Timing
- Reset: `bf_valid`, `out_valid`, `out_is_diff`, `frame_done` = 0. All data outputs = 0. `out_idx`=0. State FILL, so `in_ready=1`.
- Sum latency: second-half sample `k` accepted at the edge ending cycle t:
  - cycle t+1: `bf_valid`;
  - cycle t+2: `bf_sum` returned;
  - cycle t+3: `out_valid` with the sum.
- Drain timing: with the last pair accepted in cycle t:
  - FLUSH = t+1, t+2;
  - DRAIN reads = t+3 … t+2+NUM_PAIR;
  - diff outputs = t+4 … t+3+NUM_PAIR, back-to-back after the last sum (t+3);
  - `frame_done` at t+3+NUM_PAIR.
- `in_ready` falls in cycle t+1 and rises in cycle t+3+NUM_PAIR (FILL re-entered).
- Input gaps in FILL/PAIR produce matching gaps in `bf_valid` and the sum outputs. The diff half is always contiguous.
- Reset asserted mid-frame: everything returns immediately to reset values.

## Test plan
- NUM_PAIR=4, WIDTH=12, bench models a 1-cycle butterfly. Input 1..8, continuous → sums 6,8,10,12 (idx 0..3, is_diff=0), then −4,−4,−4,−4 (idx 0..3, is_diff=1), 8 contiguous `out_valid` cycles, `frame_done` on the 8th.
- Same frame with `in_valid` low every other cycle → same values and order; sums spaced 2 cycles apart; diffs contiguous; `in_ready` low for exactly 2+NUM_PAIR cycles.
- Extremes, WIDTH=12: first half = 2047, second half = −2048 → sums −1, diffs 4095 (13-bit), no wrap.
- NUM_PAIR=2, back-to-back frames 1..4 then 5..8 → outputs 4,6,−2,−2 then 12,14,−2,−2; no write/read hazard on the last diff.
- `clr` asserted during PAIR after 2 pairs → no further `out_valid`; in-flight sum suppressed; next full frame 1..8 yields the correct 8 outputs.
- `rstn` pulsed low during DRAIN → all outputs 0 immediately, `in_ready=1` after release; next frame correct.
